wb_skid_stage: RTL and testbench

WB_SKID_STAGE -- requirements
Module: wb_skid_stage

---
 rtl/wb_skid_stage.sv | 161 ++++++++++++++++
 tb/tb_wb_skid_stage.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/wb_skid_stage.sv
// wb_skid_stage
//   Two-entry skid buffer sitting in front of the register-file write port.
//   Beats are captured into MAIN (the head, driven straight onto OUT_*).
//   A second beat that arrives while the head is stalled is parked in SKID.
//   Lane enables are cleaned at capture time:
//     - writes to register 0 are dropped;
//     - when several enabled lanes target the same register, only the
//       highest-index lane keeps its enable.
//
// Ports
//   CLOCK             rising-edge clock
//   RESET             synchronous, active-high; highest priority
//   FLUSH             synchronous discard of all held beats (beats offered
//                     in the same cycle are dropped)
//   IN_VALID/IN_READY upstream handshake; IN_READY depends on state only
//   IN_WriteData      LANES x DATA_W, lane k at [k*DATA_W +: DATA_W]
//   IN_WriteRegister  LANES x REG_W, packed the same way
//   IN_WriteEnable    LANES per-lane write request
//   OUT_VALID/OUT_READY downstream handshake
//   OUT_Write*        fields of the head beat (MAIN)
//   OCCUPANCY         held beats: 0, 1 or 2
module wb_skid_stage #(
  parameter int DATA_W = 32,
  parameter int REG_W  = 5,
  parameter int LANES  = 1
) (
  input  logic                      CLOCK,
  input  logic                      RESET,
  input  logic                      FLUSH,
  input  logic                      IN_VALID,
  output logic                      IN_READY,
  input  logic [LANES*DATA_W-1:0]   IN_WriteData,
  input  logic [LANES*REG_W-1:0]    IN_WriteRegister,
  input  logic [LANES-1:0]          IN_WriteEnable,
  output logic                      OUT_VALID,
  input  logic                      OUT_READY,
  output logic [LANES*DATA_W-1:0]   OUT_WriteData,
  output logic [LANES*REG_W-1:0]    OUT_WriteRegister,
  output logic [LANES-1:0]          OUT_WriteEnable,
  output logic [1:0]                OCCUPANCY
);

  // State value doubles as the occupancy count.
  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } stateT;

  stateT                    state;
  logic [LANES*DATA_W-1:0]  mainData;
  logic [LANES*REG_W-1:0]   mainReg;
  logic [LANES-1:0]         mainEn;
  logic [LANES*DATA_W-1:0]  skidData;
  logic [LANES*REG_W-1:0]   skidReg;
  logic [LANES-1:0]         skidEn;

  logic                     inFire;
  logic                     outFire;
  logic [LANES-1:0]         inEnClean;

  // Drop writes to register 0 and resolve same-register conflicts in favour
  // of the highest-index lane.
  function automatic logic [LANES-1:0] cleanEnables(
    input logic [LANES-1:0]       en,
    input logic [LANES*REG_W-1:0] regs
  );
    logic [LANES-1:0] result;
    logic [REG_W-1:0] regK;
    logic [REG_W-1:0] regJ;
    result = {LANES{1'b0}};
    for (int k = 0; k < LANES; k++) begin
      regK      = regs[k*REG_W +: REG_W];
      result[k] = en[k] & (regK != {REG_W{1'b0}});
      for (int j = k + 1; j < LANES; j++) begin
        regJ      = regs[j*REG_W +: REG_W];
        result[k] = result[k] & ~(en[j] & (regJ == regK));
      end
    end
    return result;
  endfunction

  // Handshake decode; both readies come from the registered state only,
  // so there is no combinational OUT_READY -> IN_READY path.
  assign IN_READY  = (state != FULL);
  assign OUT_VALID = (state != EMPTY);
  assign inFire    = IN_VALID & IN_READY;
  assign outFire   = OUT_VALID & OUT_READY;
  assign inEnClean = cleanEnables(IN_WriteEnable, IN_WriteRegister);

  // Head fields come straight from MAIN registers. MAIN is zeroed whenever
  // the buffer drains, so the enable is already all-zero while not valid.
  assign OUT_WriteData     = mainData;
  assign OUT_WriteRegister = mainReg;
  assign OUT_WriteEnable   = mainEn;
  assign OCCUPANCY         = state;

  // Skid-buffer FSM: reset, then flush, then the handshake transitions.
  always_ff @(posedge CLOCK) begin
    if (RESET || FLUSH) begin
      state    <= EMPTY;
      mainData <= {(LANES*DATA_W){1'b0}};
      mainReg  <= {(LANES*REG_W){1'b0}};
      mainEn   <= {LANES{1'b0}};
      skidData <= {(LANES*DATA_W){1'b0}};
      skidReg  <= {(LANES*REG_W){1'b0}};
      skidEn   <= {LANES{1'b0}};
    end else begin
      case (state)
        EMPTY: begin
          if (inFire) begin
            mainData <= IN_WriteData;
            mainReg  <= IN_WriteRegister;
            mainEn   <= inEnClean;
            state    <= ONE;
          end
        end
        ONE: begin
          if (inFire && outFire) begin
            // Head leaves and the new beat replaces it in the same cycle.
            mainData <= IN_WriteData;
            mainReg  <= IN_WriteRegister;
            mainEn   <= inEnClean;
          end else if (inFire) begin
            skidData <= IN_WriteData;
            skidReg  <= IN_WriteRegister;
            skidEn   <= inEnClean;
            state    <= FULL;
          end else if (outFire) begin
            mainData <= {(LANES*DATA_W){1'b0}};
            mainReg  <= {(LANES*REG_W){1'b0}};
            mainEn   <= {LANES{1'b0}};
            state    <= EMPTY;
          end
        end
        FULL: begin
          // IN_READY is low here, so only the drain path exists.
          if (outFire) begin
            mainData <= skidData;
            mainReg  <= skidReg;
            mainEn   <= skidEn;
            skidData <= {(LANES*DATA_W){1'b0}};
            skidReg  <= {(LANES*REG_W){1'b0}};
            skidEn   <= {LANES{1'b0}};
            state    <= ONE;
          end
        end
        default: begin
          state    <= EMPTY;
          mainData <= {(LANES*DATA_W){1'b0}};
          mainReg  <= {(LANES*REG_W){1'b0}};
          mainEn   <= {LANES{1'b0}};
          skidData <= {(LANES*DATA_W){1'b0}};
          skidReg  <= {(LANES*REG_W){1'b0}};
          skidEn   <= {LANES{1'b0}};
        end
      endcase
    end
  end

endmodule

// File: tb/tb_wb_skid_stage.sv
module tb_wb_skid_stage;

  localparam int DW = 32;
  localparam int RW = 5;
  localparam int LN = 2;

  logic          CLOCK;
  logic          RESET;
  logic          FLUSH;
  logic          IN_VALID;
  logic          IN_READY;
  logic [63:0]   IN_WriteData;
  logic [9:0]    IN_WriteRegister;
  logic [1:0]    IN_WriteEnable;
  logic          OUT_VALID;
  logic          OUT_READY;
  logic [63:0]   OUT_WriteData;
  logic [9:0]    OUT_WriteRegister;
  logic [1:0]    OUT_WriteEnable;
  logic [1:0]    OCCUPANCY;

  wb_skid_stage #(.DATA_W(DW), .REG_W(RW), .LANES(LN)) dut (
    .CLOCK             (CLOCK),
    .RESET             (RESET),
    .FLUSH             (FLUSH),
    .IN_VALID          (IN_VALID),
    .IN_READY          (IN_READY),
    .IN_WriteData      (IN_WriteData),
    .IN_WriteRegister  (IN_WriteRegister),
    .IN_WriteEnable    (IN_WriteEnable),
    .OUT_VALID         (OUT_VALID),
    .OUT_READY         (OUT_READY),
    .OUT_WriteData     (OUT_WriteData),
    .OUT_WriteRegister (OUT_WriteRegister),
    .OUT_WriteEnable   (OUT_WriteEnable),
    .OCCUPANCY         (OCCUPANCY)
  );

  initial CLOCK = 1'b0;
  always #5 CLOCK = ~CLOCK;

  typedef struct packed {
    logic [63:0] data;
    logic [9:0]  regs;
    logic [1:0]  en;
  } beatT;

  // Reference model: an ordered list of accepted beats, head at index 0.
  beatT model[$];
  int   compared = 0;
  int   mismatched = 0;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Walk lanes from highest to lowest; a lane keeps its write only if its
  // register is nonzero and not already claimed by a higher lane.
  function automatic logic [1:0] modelClean(input logic [1:0] en, input logic [9:0] regs);
    logic [31:0] claimed;
    logic [1:0]  res;
    logic [4:0]  r;
    claimed = 32'd0;
    res     = 2'b00;
    for (int k = 1; k >= 0; k--) begin
      r = regs[k*5 +: 5];
      if (en[k] && r != 5'd0) begin
        if (!claimed[r]) res[k] = 1'b1;
        claimed[r] = 1'b1;
      end
    end
    return res;
  endfunction

  task automatic checkAll();
    chk("occupancy", 128'(OCCUPANCY), 128'(model.size()));
    chk("in_ready", 128'(IN_READY), 128'(model.size() < 2));
    chk("out_valid", 128'(OUT_VALID), 128'(model.size() > 0));
    if (model.size() > 0)
      chk("head_beat", 128'({OUT_WriteData, OUT_WriteRegister, OUT_WriteEnable}), 128'(model[0]));
    else
      chk("idle_enable", 128'(OUT_WriteEnable), 128'(2'b00));
  endtask

  // One clock: drive inputs, advance the model across the edge, check.
  task automatic cycle(input logic v, input logic [63:0] d, input logic [9:0] r,
                       input logic [1:0] e, input logic ordy, input logic fl, input logic rs);
    int   n;
    beatT b;
    IN_VALID = v; IN_WriteData = d; IN_WriteRegister = r; IN_WriteEnable = e;
    OUT_READY = ordy; FLUSH = fl; RESET = rs;
    n = model.size();
    @(posedge CLOCK);
    #1;
    if (rs || fl) begin
      model.delete();
    end else begin
      if (n > 0 && ordy) model.delete(0);
      if (v && n < 2) begin
        b.data = d; b.regs = r; b.en = modelClean(e, r);
        model.push_back(b);
      end
    end
    checkAll();
  endtask

  task automatic idle(input logic ordy);
    cycle(1'b0, 64'd0, 10'd0, 2'b00, ordy, 1'b0, 1'b0);
  endtask

  initial begin
    IN_VALID = 1'b0; IN_WriteData = 64'd0; IN_WriteRegister = 10'd0;
    IN_WriteEnable = 2'b00; OUT_READY = 1'b0; FLUSH = 1'b0; RESET = 1'b1;

    // Reset state
    cycle(1'b0, 64'd0, 10'd0, 2'b00, 1'b0, 1'b0, 1'b1);
    cycle(1'b0, 64'd0, 10'd0, 2'b00, 1'b0, 1'b0, 1'b1);
    chk("reset_data", 128'(OUT_WriteData), 128'(64'd0));
    chk("reset_reg", 128'(OUT_WriteRegister), 128'(10'd0));
    chk("reset_in_ready", 128'(IN_READY), 128'(1'b1));

    // Pass-through with one-cycle latency
    cycle(1'b1, {32'h0, 32'hDEADBEEF}, {5'd0, 5'd8}, 2'b01, 1'b1, 1'b0, 1'b0);
    chk("pass_valid", 128'(OUT_VALID), 128'(1'b1));
    chk("pass_data", 128'(OUT_WriteData[31:0]), 128'(32'hDEADBEEF));
    chk("pass_reg", 128'(OUT_WriteRegister[4:0]), 128'(5'd8));
    chk("pass_en", 128'(OUT_WriteEnable), 128'(2'b01));
    chk("pass_occ", 128'(OCCUPANCY), 128'(2'd1));
    idle(1'b1);

    // Backpressure: A then B held, then drained in order
    cycle(1'b1, {32'h0, 32'hA}, {5'd0, 5'd1}, 2'b01, 1'b0, 1'b0, 1'b0);
    cycle(1'b1, {32'h0, 32'hB}, {5'd0, 5'd2}, 2'b01, 1'b0, 1'b0, 1'b0);
    chk("bp_occ", 128'(OCCUPANCY), 128'(2'd2));
    chk("bp_in_ready", 128'(IN_READY), 128'(1'b0));
    chk("bp_head_a", 128'(OUT_WriteData[31:0]), 128'(32'hA));
    cycle(1'b1, {32'h0, 32'hC}, {5'd0, 5'd3}, 2'b01, 1'b0, 1'b0, 1'b0);
    idle(1'b1);
    chk("bp_head_b", 128'(OUT_WriteData[31:0]), 128'(32'hB));
    chk("bp_ready_after_a", 128'(IN_READY), 128'(1'b1));
    idle(1'b1);
    chk("bp_drained", 128'(OUT_VALID), 128'(1'b0));

    // Zero-register masking
    cycle(1'b1, {32'h0, 32'h5}, {5'd0, 5'd0}, 2'b01, 1'b0, 1'b0, 1'b0);
    chk("zero_reg_en", 128'(OUT_WriteEnable), 128'(2'b00));
    chk("zero_reg_valid", 128'(OUT_VALID), 128'(1'b1));
    idle(1'b1);

    // Lane conflict: highest lane wins
    cycle(1'b1, {32'h22, 32'h11}, {5'd9, 5'd9}, 2'b11, 1'b0, 1'b0, 1'b0);
    chk("conflict_en", 128'(OUT_WriteEnable), 128'(2'b10));
    chk("conflict_data1", 128'(OUT_WriteData[63:32]), 128'(32'h22));
    idle(1'b1);

    // Flush beats both held beats and the one offered that cycle
    cycle(1'b1, {32'h0, 32'h31}, {5'd0, 5'd4}, 2'b01, 1'b0, 1'b0, 1'b0);
    cycle(1'b1, {32'h0, 32'h32}, {5'd0, 5'd5}, 2'b01, 1'b0, 1'b0, 1'b0);
    cycle(1'b1, {32'h0, 32'h33}, {5'd0, 5'd6}, 2'b01, 1'b1, 1'b1, 1'b0);
    chk("flush_occ", 128'(OCCUPANCY), 128'(2'd0));
    chk("flush_valid", 128'(OUT_VALID), 128'(1'b0));
    idle(1'b1);
    idle(1'b1);

    // Reset beats flush and discards a full buffer
    cycle(1'b1, {32'h0, 32'h41}, {5'd0, 5'd7}, 2'b01, 1'b0, 1'b0, 1'b0);
    cycle(1'b1, {32'h0, 32'h42}, {5'd0, 5'd7}, 2'b01, 1'b0, 1'b0, 1'b0);
    cycle(1'b1, {32'h0, 32'h43}, {5'd0, 5'd7}, 2'b01, 1'b1, 1'b1, 1'b1);
    chk("rst_occ", 128'(OCCUPANCY), 128'(2'd0));
    chk("rst_valid", 128'(OUT_VALID), 128'(1'b0));
    chk("rst_data", 128'(OUT_WriteData), 128'(64'd0));
    chk("rst_reg", 128'(OUT_WriteRegister), 128'(10'd0));
    chk("rst_in_ready", 128'(IN_READY), 128'(1'b1));
    idle(1'b1);

    // Random stall / ready stress against the queue model
    for (int i = 0; i < 800; i++) begin
      logic [63:0] d;
      logic [9:0]  r;
      logic        fl;
      d  = {$urandom(), $urandom()};
      if ($urandom_range(0, 1) == 0)
        r = {5'($urandom_range(0, 3)), 5'($urandom_range(0, 3))};
      else
        r = 10'($urandom());
      fl = ($urandom_range(0, 49) == 0);
      cycle(1'($urandom_range(0, 1)), d, r, 2'($urandom_range(0, 3)),
            ($urandom_range(0, 9) < 6), fl, 1'b0);
    end
    for (int i = 0; i < 3; i++) idle(1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
